td4_program_loader: RTL and testbench
=====================================

// Module: td4_program_loader
// PURPOSE
//  Serial program loader sitting directly upstream of the TD4 program memory.
//  Receives a framed 8N1 UART byte stream, writes 16 instruction words into
//  memory addresses 0..15, and verifies the load with a checksum.
//  Holds the CPU in reset while a load is in progress.
// PARAMETERS
//  CLK_DIV     16     clk cycles per UART bit (>=4, even)
//  SYNC_BYTE   8'h5A  frame-start marker
//  PROG_DEPTH  16     program words per frame (fixed to match 4-bit PC)
// PORTS
//  clk            in   1  system clock
//  rst_n          in   1  asynchronous, active-low reset
//  rx             in   1  UART serial input, idle high, LSB first, async to clk
//  mem_we         out  1  memory write strobe, active high, one clk pulse per word
//  mem_addr       out  4  write address
//  mem_opcode     out  4  opcode to memory (received byte bits [3:0])
//  mem_immediate  out  4  immediate to memory (received byte bits [7:4])
//  cpu_hold       out  1  high = top level keeps the CPU in reset
//  busy           out  1  high in LOAD or CHECK
//  done           out  1  last frame loaded and checksum matched (sticky)
//  error          out  1  last frame failed on checksum or framing (sticky)
// BEHAVIOUR
//  Reset: every output 0; FSM in IDLE; rx sync FFs preset to 1.
//  RX path
//   - Two-FF synchroniser on rx; a falling edge on the synced signal arms a bit counter.
//   - Start bit re-sampled at CLK_DIV/2. If it is high again, the edge was a glitch: abort, stay idle.
//   - Sample 8 data bits, then the stop bit, each CLK_DIV cycles apart.
//   - Stop bit = 1: byte_valid pulses 1 clk at the stop-bit sample.
//   - Stop bit = 0: frame_err pulses instead and no byte is delivered.
//   - The receiver accepts the next start bit right after the stop-bit sample.
//  Loader FSM: IDLE, LOAD, CHECK, DONE, ERROR
//   - IDLE: non-SYNC bytes are ignored. SYNC -> LOAD; clear count and sum; cpu_hold=1, done=0, error=0.
//   - LOAD: each byte_valid drives the outputs on the next clk:
//     - mem_we=1 for 1 clk;
//     - mem_addr=count, mem_opcode=byte[3:0], mem_immediate=byte[7:4].
//     - sum += byte (8-bit, mod 256).
//     - count increments; after word PROG_DEPTH-1 -> CHECK. Count never wraps inside LOAD.
//   - CHECK: the next byte is compared against sum.
//     - Equal -> DONE: cpu_hold=0, done=1.
//     - Not equal -> ERROR: error=1, cpu_hold stays 1.
//   - DONE/ERROR: a SYNC byte restarts exactly as from IDLE. Other bytes are ignored.
//   - frame_err in LOAD or CHECK -> ERROR; no further writes.
//   - frame_err in IDLE/DONE/ERROR is ignored.
//   - The SYNC value inside LOAD is ordinary data (no resync mid-frame).
//   - mem_addr/opcode/immediate hold their last values when mem_we=0.
//   - busy = (state==LOAD || state==CHECK).
//   - Async reset mid-load returns to IDLE with outputs 0. Words already written stay in memory.
//  Simultaneous events: only one of byte_valid/frame_err can occur per clk. No other races.
// STRUCTURE
//  Shared package td4_loader_pkg holds:
//   - state encoding (IDLE=0..ERROR=4);
//   - SYNC_BYTE default;
//   - byte field slices OPC_LSB=0, IMM_LSB=4.
//  Sub-module td4_uart_rx(clk, rst_n, rx, byte_o[7:0], byte_valid, frame_err)
//   contains the synchroniser and bit timing.
//  The top part holds the FSM, word counter, checksum and output registers.
// TESTING (CLK_DIV=16)
//  1 Reset: rst_n low with rx idle -> all outputs 0.
//    Release: no mem_we for 1000 clks.
//  2 Good load: send 5A, 00..0F, 78.
//    -> 16 mem_we pulses, addr i with opcode i and immediate 0.
//    -> busy=1 during the frame, then done=1 and cpu_hold=0.
//  3 Bad checksum: same frame ending 00 -> error=1, cpu_hold=1.
//    Then resend test 2 -> done=1, error=0.
//  4 Junk before sync: send 12, 34, then the test-2 frame.
//    -> writes start only after 5A; exactly 16 pulses.
//  5 Framing/glitch:
//    - rx low for 6 clks -> no byte.
//    - stop bit 0 on word 5 -> error=1; no mem_we after addr 4.
//  6 Reset mid-load after word 7 -> outputs 0 and state IDLE.
//    Data bytes then produce no writes until the next 5A.

Source files
------------

// File: rtl/td4_loader_pkg.sv
// rtl/td4_loader_pkg.sv - shared constants and state encodings for the TD4 program loader
package td4_loader_pkg;

    localparam int         PROG_DEPTH        = 16;
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h5A;
    localparam int         OPC_LSB           = 0;
    localparam int         IMM_LSB           = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } ld_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/td4_uart_rx.sv
// rtl/td4_uart_rx.sv - 8N1 UART receiver with two-FF synchroniser and mid-bit sampling
module td4_uart_rx
    import td4_loader_pkg::*;
#(
    parameter int CLK_DIV = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] byte_o,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int            CW        = $clog2(CLK_DIV);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLK_DIV - 1);

    rx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          rx_meta_q, rx_sync_q, rx_prev_q;
    logic          fall_edge;

    assign fall_edge = rx_prev_q & ~rx_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (fall_edge) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                // A start bit that is high again at mid-bit was only a glitch.
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    valid_d = rx_sync_q;
                    ferr_d  = ~rx_sync_q;
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_o     = shift_q;
    assign byte_valid = valid_q;
    assign frame_err  = ferr_q;

endmodule

// File: rtl/td4_program_loader.sv
// rtl/td4_program_loader.sv - loads 16 TD4 instruction words from a UART frame and verifies a checksum
module td4_program_loader
    import td4_loader_pkg::*;
#(
    parameter int         CLK_DIV   = 16,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       mem_we,
    output logic [3:0] mem_addr,
    output logic [3:0] mem_opcode,
    output logic [3:0] mem_immediate,
    output logic       cpu_hold,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam logic [3:0] LAST_ADDR = 4'(PROG_DEPTH - 1);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_ferr;

    td4_uart_rx #(
        .CLK_DIV (CLK_DIV)
    ) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .byte_o     (rx_byte),
        .byte_valid (rx_valid),
        .frame_err  (rx_ferr)
    );

    ld_state_e  state_q, state_d;
    logic [3:0] count_q, count_d;
    logic [7:0] sum_q, sum_d;
    logic       we_q, we_d;
    logic [3:0] addr_q, addr_d;
    logic [3:0] opc_q, opc_d;
    logic [3:0] imm_q, imm_d;
    logic       hold_q, hold_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            sum_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            opc_q   <= '0;
            imm_q   <= '0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            sum_q   <= sum_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            opc_q   <= opc_d;
            imm_q   <= imm_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        sum_d   = sum_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        opc_d   = opc_q;
        imm_d   = imm_q;
        hold_d  = hold_q;
        done_d  = done_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (rx_valid && rx_byte == SYNC_BYTE) begin
                    state_d = ST_LOAD;
                    count_d = '0;
                    sum_d   = '0;
                    hold_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                // Inside a frame every byte is data, including the sync value.
                if (rx_valid) begin
                    we_d    = 1'b1;
                    addr_d  = count_q;
                    opc_d   = rx_byte[OPC_LSB +: 4];
                    imm_d   = rx_byte[IMM_LSB +: 4];
                    sum_d   = sum_q + rx_byte;
                    if (count_q == LAST_ADDR) begin
                        state_d = ST_CHECK;
                    end else begin
                        count_d = count_q + 4'd1;
                    end
                end else if (rx_ferr) begin
                    state_d = ST_ERROR;
                    err_d   = 1'b1;
                end
            end
            ST_CHECK: begin
                if (rx_valid) begin
                    if (rx_byte == sum_q) begin
                        state_d = ST_DONE;
                        hold_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_ERROR;
                        err_d   = 1'b1;
                    end
                end else if (rx_ferr) begin
                    state_d = ST_ERROR;
                    err_d   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mem_we        = we_q;
    assign mem_addr      = addr_q;
    assign mem_opcode    = opc_q;
    assign mem_immediate = imm_q;
    assign cpu_hold      = hold_q;
    assign done          = done_q;
    assign error         = err_q;
    assign busy          = (state_q == ST_LOAD) || (state_q == ST_CHECK);

endmodule

// File: tb/tb_td4_program_loader.sv
// tb/tb_td4_program_loader.sv - scoreboard bench for td4_program_loader with a frame-level reference model
module tb_td4_program_loader;

    localparam int CLK_DIV = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [3:0] mem_opcode;
    logic [3:0] mem_immediate;
    logic       cpu_hold;
    logic       busy;
    logic       done;
    logic       error;

    td4_program_loader #(
        .CLK_DIV   (CLK_DIV),
        .SYNC_BYTE (8'h5A)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx            (rx),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_opcode    (mem_opcode),
        .mem_immediate (mem_immediate),
        .cpu_hold      (cpu_hold),
        .busy          (busy),
        .done          (done),
        .error         (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int opc;
        int imm;
    } wr_t;

    wr_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;

    // Reference model: 0 = waiting for sync, 1 = collecting words, 2 = awaiting checksum
    int m_mode = 0;
    int m_cnt  = 0;
    int m_sum  = 0;
    int m_done = 0;
    int m_err  = 0;
    int m_hold = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_cnt = 0; m_sum = 0;
        m_done = 0; m_err = 0; m_hold = 0;
    endtask

    task automatic model_byte(input int b, input bit stop_ok);
        wr_t w;
        if (!stop_ok) begin
            if (m_mode != 0) begin
                m_mode = 0;
                m_err  = 1;
            end
            return;
        end
        case (m_mode)
            0: if (b == 'h5A) begin
                m_mode = 1; m_cnt = 0; m_sum = 0;
                m_hold = 1; m_done = 0; m_err = 0;
            end
            1: begin
                w.addr = m_cnt; w.opc = b % 16; w.imm = b / 16;
                exp_q.push_back(w);
                m_sum = (m_sum + b) % 256;
                m_cnt++;
                if (m_cnt == 16) m_mode = 2;
            end
            default: begin
                if (b == m_sum) begin
                    m_done = 1; m_hold = 0;
                end else begin
                    m_err = 1;
                end
                m_mode = 0;
            end
        endcase
    endtask

    task automatic check_status();
        chk("busy", busy, (m_mode != 0) ? 1 : 0);
        chk("done", done, m_done);
        chk("error", error, m_err);
        chk("cpu_hold", cpu_hold, m_hold);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        model_byte(int'(b), stop_ok);
        rx = 1'b0;
        repeat (CLK_DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CLK_DIV) @(negedge clk);
        end
        rx = stop_ok;
        repeat (CLK_DIV) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        check_status();
    endtask

    task automatic send_frame(input logic [7:0] data [16], input logic [7:0] csum, input int bad_word);
        send_byte(8'h5A, 1'b1);
        for (int i = 0; i < 16; i++) begin
            send_byte(data[i], i != bad_word);
        end
        send_byte(csum, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_opcode"}, mem_opcode, 0);
        chk({tag, "_mem_imm"}, mem_immediate, 0);
        chk({tag, "_cpu_hold"}, cpu_hold, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
    endtask

    // Monitor: every write strobe must match the oldest expected write
    always @(negedge clk) begin
        if (rst_n === 1'b1 && mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write addr=%0d opcode=%0d imm=%0d expected=none",
                         mem_addr, mem_opcode, mem_immediate);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", mem_addr, e.addr);
                chk("wr_opcode", mem_opcode, e.opc);
                chk("wr_imm", mem_immediate, e.imm);
            end
        end
    end

    logic [7:0] seq_data [16];
    logic [7:0] rnd_data [16];

    initial begin
        int sum;
        rx    = 1'b1;
        rst_n = 1'b0;
        for (int i = 0; i < 16; i++) seq_data[i] = 8'(i);

        // 1: reset state, then a quiet line produces nothing
        repeat (5) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (1000) @(negedge clk);
        chk("idle_no_writes", exp_q.size(), 0);
        check_status();

        // 2: good load
        send_frame(seq_data, 8'h78, -1);
        chk("t2_done", done, 1);
        chk("t2_hold", cpu_hold, 0);
        chk("t2_error", error, 0);

        // 3: bad checksum, then recovery
        send_frame(seq_data, 8'h00, -1);
        chk("t3_error", error, 1);
        chk("t3_hold", cpu_hold, 1);
        chk("t3_done", done, 0);
        send_frame(seq_data, 8'h78, -1);
        chk("t3_redone", done, 1);
        chk("t3_reerror", error, 0);

        // 4: junk before sync
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_frame(seq_data, 8'h78, -1);
        chk("t4_done", done, 1);

        // 5: start-bit glitch, then stop-bit error on word 5
        rx = 1'b0;
        repeat (6) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CLK_DIV) @(negedge clk);
        check_status();
        send_frame(seq_data, 8'h78, 5);
        chk("t5_error", error, 1);
        chk("t5_hold", cpu_hold, 1);
        chk("t5_done", done, 0);

        // 6: reset after word 7
        send_byte(8'h5A, 1'b1);
        for (int i = 0; i < 8; i++) send_byte(seq_data[i], 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_writes_before_reset", exp_q.size(), 0);
        check_all_zero("midreset");
        model_reset();
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        send_byte(8'h08, 1'b1);
        send_byte(8'h09, 1'b1);
        send_byte(8'hA5, 1'b1);
        send_frame(seq_data, 8'h78, -1);
        chk("t6_done", done, 1);

        // Randomized frames: junk, random data, random checksum validity and framing faults
        for (int f = 0; f < 6; f++) begin
            int junk;
            int bad;
            logic [7:0] cs;
            junk = int'($urandom_range(0, 2));
            for (int j = 0; j < junk; j++) send_byte(8'($urandom), 1'b1);
            sum = 0;
            for (int i = 0; i < 16; i++) begin
                rnd_data[i] = 8'($urandom);
                sum = (sum + int'(rnd_data[i])) % 256;
            end
            cs  = 8'(sum);
            if ($urandom_range(0, 1) == 0) cs = cs ^ 8'(int'($urandom_range(1, 255)));
            bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
            send_frame(rnd_data, cs, bad);
        end

        repeat (50) @(negedge clk);
        chk("pending_writes", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
